// File: rtl/bmp_stream_reader_if.sv
// rtl/bmp_stream_reader_if.sv - memory read port and pixel-pair stream of the bmp frame source
interface bmp_stream_reader_if #(
  parameter int ADDR_W = 18
);
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;
  logic              VSYNC;
  logic              HSYNC;
  logic [7:0]        DATA_R0, DATA_G0, DATA_B0;
  logic [7:0]        DATA_R1, DATA_G1, DATA_B1;

  modport master (
    output mem_addr,
    input  mem_rdata,
    output VSYNC, HSYNC,
    output DATA_R0, DATA_G0, DATA_B0,
    output DATA_R1, DATA_G1, DATA_B1
  );

  modport slave (
    input  mem_addr,
    output mem_rdata,
    input  VSYNC, HSYNC,
    input  DATA_R0, DATA_G0, DATA_B0,
    input  DATA_R1, DATA_G1, DATA_B1
  );
endinterface

// File: rtl/bmp_stream_reader.sv
// rtl/bmp_stream_reader.sv - 24-bit bmp frame source emitting top-down RGB888 pixel pairs
// Optional header validation (HEADER/ERROR states) is enabled by defining BMP_READ_HDR_CHECK_EN.
module bmp_stream_reader #(
  parameter int WIDTH          = 100,
  parameter int HEIGHT         = 100,
  parameter int BMP_HEADER_NUM = 54,
  parameter int START_UP_DELAY = 100,
  parameter int HSYNC_DELAY    = 160,
  parameter int ADDR_W         = 18
) (
  input  logic                HCLK,
  input  logic                HRESET,
  input  logic                start,
  bmp_stream_reader_if.master bus,
  output logic                ctrl_done,
  output logic                hdr_err
);

  typedef enum logic [2:0] {
    IDLE, HEADER, WAIT, FETCH, EMIT, HBLANK, DONE, ERROR
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ROW_BASE = ADDR_W'(BMP_HEADER_NUM + 3 * WIDTH * (HEIGHT - 1));
  localparam logic [ADDR_W-1:0] ROW_STEP      = ADDR_W'(3 * WIDTH);
  localparam logic [ADDR_W-1:0] ADDR_ONE      = ADDR_W'(1);
  localparam logic [15:0]       WAIT_LAST     = 16'(START_UP_DELAY - 1);
  localparam logic [15:0]       BLANK_LAST    = 16'(HSYNC_DELAY - 1);
  localparam logic [15:0]       PAIR_LAST     = 16'(WIDTH / 2 - 1);
  localparam logic [15:0]       ROW_LAST      = 16'(HEIGHT - 1);

  if ((longint'(BMP_HEADER_NUM) + 3 * longint'(WIDTH) * longint'(HEIGHT) - 1) >= (longint'(1) << ADDR_W))
  begin : g_addr_overflow
    $error("bmp_stream_reader: ADDR_W too narrow for the image size");
  end

  state_t      state;
  logic [15:0] cnt;
  logic [15:0] pair_idx;
  logic [15:0] row_idx;
  logic [ADDR_W-1:0] row_base;
  logic [7:0]  sh_b0, sh_g0, sh_r0, sh_b1, sh_g1;

`ifdef BMP_READ_HDR_CHECK_EN
  localparam logic [15:0] HDR_LAST      = 16'(BMP_HEADER_NUM);
  localparam logic [15:0] HDR_ADDR_LAST = 16'(BMP_HEADER_NUM - 1);

  logic        hdr_bad;
  logic        hdr_err_q;
  logic [15:0] hdr_idx;
  logic        hdr_mismatch;

  assign hdr_err = hdr_err_q;

  // While in HEADER, cnt-1 is the index of the byte currently on mem_rdata.
  always_comb begin
    hdr_idx      = cnt - 16'd1;
    hdr_mismatch = 1'b0;
    if (state == HEADER && cnt != 16'd0) begin
      case (hdr_idx)
        16'd0:   hdr_mismatch = (bus.mem_rdata != 8'd66);
        16'd1:   hdr_mismatch = (bus.mem_rdata != 8'd77);
        16'd10:  hdr_mismatch = (bus.mem_rdata != 8'd54);
        16'd18:  hdr_mismatch = (bus.mem_rdata != 8'(WIDTH));
        16'd22:  hdr_mismatch = (bus.mem_rdata != 8'(HEIGHT));
        16'd28:  hdr_mismatch = (bus.mem_rdata != 8'd24);
        default: hdr_mismatch = 1'b0;
      endcase
    end
  end
`else
  assign hdr_err = 1'b0;
`endif

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state        <= IDLE;
      cnt          <= '0;
      pair_idx     <= '0;
      row_idx      <= '0;
      row_base     <= '0;
      sh_b0        <= '0;
      sh_g0        <= '0;
      sh_r0        <= '0;
      sh_b1        <= '0;
      sh_g1        <= '0;
      bus.mem_addr <= '0;
      bus.VSYNC    <= 1'b0;
      bus.HSYNC    <= 1'b0;
      bus.DATA_R0  <= '0;
      bus.DATA_G0  <= '0;
      bus.DATA_B0  <= '0;
      bus.DATA_R1  <= '0;
      bus.DATA_G1  <= '0;
      bus.DATA_B1  <= '0;
      ctrl_done    <= 1'b0;
`ifdef BMP_READ_HDR_CHECK_EN
      hdr_bad      <= 1'b0;
      hdr_err_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cnt <= '0;
`ifdef BMP_READ_HDR_CHECK_EN
            state        <= HEADER;
            bus.mem_addr <= '0;
            hdr_bad      <= 1'b0;
`else
            state <= WAIT;
`endif
          end
        end
`ifdef BMP_READ_HDR_CHECK_EN
        HEADER: begin
          if (cnt < HDR_ADDR_LAST) bus.mem_addr <= bus.mem_addr + ADDR_ONE;
          if (hdr_mismatch) hdr_bad <= 1'b1;
          if (cnt == HDR_LAST) begin
            cnt <= '0;
            if (hdr_bad || hdr_mismatch) begin
              state     <= ERROR;
              hdr_err_q <= 1'b1;
            end else begin
              state <= WAIT;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ERROR: state <= ERROR;
`endif
        WAIT: begin
          if (cnt == WAIT_LAST) begin
            state        <= FETCH;
            cnt          <= '0;
            bus.VSYNC    <= 1'b1;
            bus.mem_addr <= LAST_ROW_BASE;
            row_base     <= LAST_ROW_BASE;
            pair_idx     <= '0;
            row_idx      <= '0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        // Six address cycles plus one drain; the last byte goes straight to DATA_R1.
        FETCH: begin
          cnt <= cnt + 16'd1;
          if (cnt < 16'd5) bus.mem_addr <= bus.mem_addr + ADDR_ONE;
          case (cnt)
            16'd1: sh_b0 <= bus.mem_rdata;
            16'd2: sh_g0 <= bus.mem_rdata;
            16'd3: sh_r0 <= bus.mem_rdata;
            16'd4: sh_b1 <= bus.mem_rdata;
            16'd5: sh_g1 <= bus.mem_rdata;
            16'd6: begin
              bus.DATA_B0 <= sh_b0;
              bus.DATA_G0 <= sh_g0;
              bus.DATA_R0 <= sh_r0;
              bus.DATA_B1 <= sh_b1;
              bus.DATA_G1 <= sh_g1;
              bus.DATA_R1 <= bus.mem_rdata;
              bus.HSYNC   <= 1'b1;
              state       <= EMIT;
            end
            default: ;
          endcase
        end
        EMIT: begin
          bus.HSYNC <= 1'b0;
          cnt       <= '0;
          if (pair_idx != PAIR_LAST) begin
            pair_idx     <= pair_idx + 16'd1;
            bus.mem_addr <= bus.mem_addr + ADDR_ONE;
            state        <= FETCH;
          end else if (row_idx != ROW_LAST) begin
            pair_idx     <= '0;
            row_idx      <= row_idx + 16'd1;
            row_base     <= row_base - ROW_STEP;
            bus.mem_addr <= row_base - ROW_STEP;
            state        <= HBLANK;
          end else begin
            bus.VSYNC <= 1'b0;
            ctrl_done <= 1'b1;
            state     <= DONE;
          end
        end
        HBLANK: begin
          if (cnt == BLANK_LAST) begin
            cnt   <= '0;
            state <= FETCH;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        DONE: begin
          ctrl_done <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bmp_stream_reader.sv
// tb/tb_bmp_stream_reader.sv - scoreboard bench for bmp_stream_reader on a small 12x5 image
module tb_bmp_stream_reader;

  localparam int W    = 12;
  localparam int H    = 5;
  localparam int HD   = 20;
  localparam int SUD  = 100;
  localparam int HN   = 54;
  localparam int PPR  = W / 2;
  localparam int NP   = W * H / 2;
`ifdef BMP_READ_HDR_CHECK_EN
  localparam int VS_LAT = 55 + SUD + 1;
`else
  localparam int VS_LAT = SUD + 1;
`endif

  typedef struct {
    logic [47:0] data;
    int          gap;
  } exp_t;

  logic HCLK = 1'b0;
  logic HRESET;
  logic start;
  logic ctrl_done;
  logic hdr_err;

  bmp_stream_reader_if #(.ADDR_W(18)) bus ();

  bmp_stream_reader #(
    .WIDTH(W), .HEIGHT(H), .BMP_HEADER_NUM(HN),
    .START_UP_DELAY(SUD), .HSYNC_DELAY(HD), .ADDR_W(18)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET), .start(start),
    .bus(bus), .ctrl_done(ctrl_done), .hdr_err(hdr_err)
  );

  always #5 HCLK = ~HCLK;

  logic [7:0] mem [0:255];
  exp_t       sb[$];
  int cyc = 0;
  int n_cmp = 0, n_err = 0;
  int hs_count = 0, done_count = 0, vs_rises = 0;
  int exp_vs = -1;
  int last_ev = 0;
  logic vs_prev = 1'b0;

  initial forever begin
    @(posedge HCLK);
    cyc++;
  end

  initial forever begin
    @(posedge HCLK);
    bus.mem_rdata <= (bus.mem_addr < 18'd256) ? mem[bus.mem_addr[7:0]] : 8'h00;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
    end
  endtask

  function automatic logic [47:0] pair_exp(input int k);
    int l, m, base;
    l    = k / PPR;
    m    = k % PPR;
    base = HN + 3 * W * (H - 1 - l) + 6 * m;
    return {mem[base + 2], mem[base + 1], mem[base], mem[base + 5], mem[base + 4], mem[base + 3]};
  endfunction

  task automatic push_frame();
    exp_t e;
    for (int k = 0; k < NP; k++) begin
      e.data = pair_exp(k);
      e.gap  = (k == 0) ? 7 : (((k % PPR) == 0) ? 8 + HD : 8);
      sb.push_back(e);
    end
  endtask

  // Monitor: sampled on the falling edge, away from the DUT's active edge.
  initial forever begin
    exp_t e;
    @(negedge HCLK);
    if (HRESET) begin
      vs_prev = 1'b0;
    end else begin
      if (bus.VSYNC && !vs_prev) begin
        vs_rises++;
        chk("vsync_rise_cycle", cyc, exp_vs);
        last_ev = cyc;
      end
      if (!bus.VSYNC && vs_prev) chk("vsync_fall_with_done", ctrl_done, 1'b1);
      if (bus.HSYNC) begin
        hs_count++;
        chk("hsync_expected", sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("pair_data", {bus.DATA_R0, bus.DATA_G0, bus.DATA_B0,
                            bus.DATA_R1, bus.DATA_G1, bus.DATA_B1}, e.data);
          chk("hsync_gap", cyc - last_ev, e.gap);
        end
        last_ev = cyc;
      end
      if (ctrl_done) begin
        done_count++;
        chk("done_after_last_hsync", cyc - last_ev, 1);
        chk("done_scoreboard_empty", sb.size(), 0);
      end
`ifndef BMP_READ_HDR_CHECK_EN
      chk("addr_not_in_header", (bus.mem_addr > 18'd0 && bus.mem_addr < 18'd54), 1'b0);
      chk("hdr_err_tied_low", hdr_err, 1'b0);
`endif
      vs_prev = bus.VSYNC;
    end
  end

  task automatic chk_zero(input string pfx);
    chk({pfx, "_mem_addr"}, bus.mem_addr, 0);
    chk({pfx, "_vsync"}, bus.VSYNC, 0);
    chk({pfx, "_hsync"}, bus.HSYNC, 0);
    chk({pfx, "_r0"}, bus.DATA_R0, 0);
    chk({pfx, "_g0"}, bus.DATA_G0, 0);
    chk({pfx, "_b0"}, bus.DATA_B0, 0);
    chk({pfx, "_r1"}, bus.DATA_R1, 0);
    chk({pfx, "_g1"}, bus.DATA_G1, 0);
    chk({pfx, "_b1"}, bus.DATA_B1, 0);
    chk({pfx, "_ctrl_done"}, ctrl_done, 0);
    chk({pfx, "_hdr_err"}, hdr_err, 0);
  endtask

  // Entered and left at posedge+2; start is high for exactly the current cycle.
  task automatic start_frame(input bit expect_frame);
    start = 1'b1;
    if (expect_frame) begin
      exp_vs = cyc + VS_LAT;
      push_frame();
    end else begin
      exp_vs = -1;
    end
    @(posedge HCLK); #2;
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget);
    for (int i = 0; i < budget && done_count == d0; i++) begin
      @(posedge HCLK); #2;
    end
    chk("done_within_budget", done_count != d0, 1'b1);
  endtask

  initial begin
    int d0, h0, n0, v0;
    HRESET = 1'b1;
    start  = 1'b0;
    for (int a = 0; a < 256; a++) mem[a] = 8'(a % 251);
`ifdef BMP_READ_HDR_CHECK_EN
    mem[0] = 8'd66; mem[1] = 8'd77; mem[10] = 8'd54;
    mem[18] = 8'(W); mem[22] = 8'(H); mem[28] = 8'd24;
`else
    for (int a = 0; a < HN; a++) mem[a] = 8'h00;
`endif
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    chk_zero("reset");
    @(posedge HCLK); #2;
    HRESET = 1'b0;
    @(posedge HCLK); #2;

    // Plain frame
    d0 = done_count; h0 = hs_count;
    start_frame(1'b1);
    wait_done(d0, 3000);
    chk("frame1_hsyncs", hs_count - h0, NP);
    chk("frame1_dones", done_count - d0, 1);
    @(negedge HCLK);
    chk("done_single_cycle", ctrl_done, 1'b0);
    @(posedge HCLK); #2;

    // start pulses every 37 cycles, then a start right after ctrl_done
    d0 = done_count; h0 = hs_count;
    start  = 1'b1;
    exp_vs = cyc + VS_LAT;
    push_frame();
    for (int k = 1; k < 3000; k++) begin
      @(posedge HCLK); #2;
      if (done_count != d0) break;
      start = ((k % 37) == 0);
    end
    chk("spam_frame_hsyncs", hs_count - h0, NP);
    chk("spam_frame_dones", done_count - d0, 1);
    d0 = done_count; h0 = hs_count;
    start_frame(1'b1);
    wait_done(d0, 3000);
    chk("back_to_back_hsyncs", hs_count - h0, NP);
    @(posedge HCLK); #2;

    // Reset during row 2, then a full frame
    d0 = done_count; h0 = hs_count;
    start_frame(1'b1);
    for (int i = 0; i < 3000 && hs_count < h0 + 2 * PPR + 1; i++) begin
      @(posedge HCLK); #2;
    end
    chk("reached_row2", hs_count >= h0 + 2 * PPR + 1, 1'b1);
    HRESET = 1'b1;
    sb.delete();
    @(posedge HCLK); #2;
    HRESET = 1'b0;
    @(negedge HCLK);
    chk_zero("midreset");
    chk("midreset_no_done", done_count - d0, 0);
    @(posedge HCLK); #2;
    d0 = done_count; h0 = hs_count;
    start_frame(1'b1);
`ifdef BMP_READ_HDR_CHECK_EN
    @(negedge HCLK);
    chk("restart_first_addr", bus.mem_addr, 0);
    @(posedge HCLK); #2;
`endif
    wait_done(d0, 3000);
    chk("restart_hsyncs", hs_count - h0, NP);

`ifdef BMP_READ_HDR_CHECK_EN
    // Corrupted signature byte
    mem[0] = 8'h00;
    @(posedge HCLK); #2;
    d0 = done_count; h0 = hs_count; v0 = vs_rises;
    n0 = cyc;
    start_frame(1'b0);
    repeat (n0 + 55 - cyc) @(posedge HCLK);
    @(negedge HCLK);
    chk("hdr_err_before_56", hdr_err, 1'b0);
    @(negedge HCLK);
    chk("hdr_err_at_56", hdr_err, 1'b1);
    repeat (10000) @(posedge HCLK);
    #2;
    chk("err_no_hsync", hs_count - h0, 0);
    chk("err_no_vsync", vs_rises - v0, 0);
    chk("err_no_done", done_count - d0, 0);
    chk("err_sticky", hdr_err, 1'b1);
    HRESET = 1'b1;
    @(posedge HCLK); #2;
    HRESET = 1'b0;
    @(negedge HCLK);
    chk("err_cleared_by_reset", hdr_err, 1'b0);
    mem[0] = 8'd66;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
